// File: rtl/dmem_access_unit.sv
// Multicycle data-memory access unit: one load/store per handshake, programmable
// commit latency, byte-lane store masking and load extraction/extension.
module dmem_access_unit #(
    parameter int unsigned DEPTH_DW = 32,
    parameter int unsigned LATENCY  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = (DEPTH_DW > 1) ? $clog2(DEPTH_DW) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // NOTE: the array is deliberately left out of reset; only its time-0 contents are defined.
    logic [63:0] mem_q [DEPTH_DW] = '{default: 64'h0};

    // With LATENCY=0 the commit happens on the accept edge, so the live request is used.
    logic        cur_we;
    logic [2:0]  cur_funct3;
    logic [63:0] cur_addr;
    logic [63:0] cur_wdata;
    logic        commit;

    always_comb begin
        if (state_q == IDLE) begin
            cur_we     = req_we;
            cur_funct3 = req_funct3;
            cur_addr   = req_addr;
            cur_wdata  = req_wdata;
        end else begin
            cur_we     = we_q;
            cur_funct3 = funct3_q;
            cur_addr   = addr_q;
            cur_wdata  = wdata_q;
        end
    end

    logic [2:0]       lane;
    logic [IDX_W-1:0] idx;
    logic             illegal, misalign, out_of_range, fault;
    logic [63:0]      rd_shifted, load_val, wdata_sh;
    logic [7:0]       size_mask, byte_en;

    assign lane = cur_addr[2:0];
    assign idx  = cur_addr[IDX_W+2:3];

    always_comb begin
        illegal      = cur_we ? cur_funct3[2] : (cur_funct3 == 3'b111);
        out_of_range = cur_addr[63:3] >= 61'(DEPTH_DW);
        case (cur_funct3[1:0])
            2'd0:    begin misalign = 1'b0;            size_mask = 8'h01; end
            2'd1:    begin misalign = cur_addr[0];     size_mask = 8'h03; end
            2'd2:    begin misalign = |cur_addr[1:0];  size_mask = 8'h0f; end
            default: begin misalign = |cur_addr[2:0];  size_mask = 8'hff; end
        endcase
        fault = illegal | misalign | out_of_range;
    end

    always_comb begin
        rd_shifted = mem_q[idx] >> {lane, 3'b000};
        case (cur_funct3)
            3'b000:  load_val = {{56{rd_shifted[7]}},  rd_shifted[7:0]};
            3'b001:  load_val = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b010:  load_val = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            3'b100:  load_val = {56'h0, rd_shifted[7:0]};
            3'b101:  load_val = {48'h0, rd_shifted[15:0]};
            3'b110:  load_val = {32'h0, rd_shifted[31:0]};
            default: load_val = rd_shifted;
        endcase
        byte_en  = size_mask << lane;
        wdata_sh = cur_wdata << {lane, 3'b000};
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (LATENCY == 0) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = 4'(LATENCY);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (commit) begin
            rdata_d = (!cur_we && !fault) ? load_val : 64'h0;
            err_d   = fault;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 64'h0;
            wdata_q  <= 64'h0;
            rdata_q  <= 64'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // A store whose commit edge meets reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && commit && cur_we && !fault) begin
            for (int b = 0; b < 8; b++) begin
                if (byte_en[b]) mem_q[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: three instances (LATENCY 0/1/3) driven with directed
// and random loads/stores, checked against a byte-array reference model.
module tb_dmem_access_unit;

    localparam int DEPTH = 32;
    localparam int NB    = 8 * DEPTH;

    logic              clk = 1'b0;
    logic [2:0]        reset;
    logic [2:0]        req_valid, req_ready, req_we, rsp_valid, rsp_err;
    logic [2:0][2:0]   req_funct3;
    logic [2:0][63:0]  req_addr, req_wdata, rsp_rdata;

    logic [7:0] mdl [3][NB];
    int n_vec     = 0;
    int n_miscmp  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 0 : (g == 1) ? 1 : 3;
        dmem_access_unit #(.DEPTH_DW(DEPTH), .LATENCY(L)) u_dut (
            .clk        (clk),
            .reset      (reset[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_funct3 (req_funct3[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory with size/sign rules.
    task automatic model_access(input int k, input logic we, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                output logic [63:0] d, output logic e);
        int  size;
        bit  illegal;
        size    = 1 << f3[1:0];
        illegal = we ? f3[2] : (f3 == 3'b111);
        e = illegal || ((addr % 64'(size)) != 0) || (addr >= 64'(NB));
        d = 64'h0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < size; i++) mdl[k][int'(addr[11:0]) + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++) d[8*i +: 8] = mdl[k][int'(addr[11:0]) + i];
                if (!f3[2] && size < 8 && d[8*size-1])
                    d = d | ~((64'd1 << (8*size)) - 64'd1);
            end
        end
    endtask

    // Issue one request from a negedge; returns at the negedge after the response.
    task automatic do_req(input int k, input logic we, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wdata, input string tag,
                          output logic [63:0] got_d, output logic got_e);
        logic [63:0] exp_d;
        logic        exp_e;
        int t, n;
        string p;
        p = $sformatf("u%0d %s", k, tag);
        t = 0;
        while (!req_ready[k] && t < 50) begin @(negedge clk); t++; end
        check({p, " ready"}, 64'(req_ready[k]), 64'd1);
        req_valid[k] = 1'b1; req_we[k] = we; req_funct3[k] = f3;
        req_addr[k] = addr; req_wdata[k] = wdata;
        model_access(k, we, f3, addr, wdata, exp_d, exp_e);
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        n = 1;
        while (!rsp_valid[k] && n < 40) begin @(negedge clk); n++; end
        check({p, " latency"}, 64'(n), 64'(lat_of(k) + 1));
        got_d = rsp_rdata[k];
        got_e = rsp_err[k];
        check({p, " rdata"}, got_d, exp_d);
        check({p, " err"}, 64'(got_e), 64'(exp_e));
        check({p, " busy in resp"}, 64'(req_ready[k]), 64'd0);
        @(negedge clk);
        check({p, " strobe width"}, 64'(rsp_valid[k]), 64'd0);
        check({p, " rdata hold"}, rsp_rdata[k], got_d);
    endtask

    initial begin
        logic [63:0] d, wd, a;
        logic        e;
        logic [2:0]  f3;
        logic        we;
        int          first, second, dw, off;

        for (int k = 0; k < 3; k++) for (int i = 0; i < NB; i++) mdl[k][i] = 8'h00;
        reset = 3'b111; req_valid = '0; req_we = '0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d reset ready", k), 64'(req_ready[k]), 64'd1);
            check($sformatf("u%0d reset valid", k), 64'(rsp_valid[k]), 64'd0);
            check($sformatf("u%0d reset rdata", k), rsp_rdata[k], 64'h0);
            check($sformatf("u%0d reset err", k), 64'(rsp_err[k]), 64'd0);
        end
        reset = 3'b000;
        @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            do_req(k, 0, 3'b011, 64'h0, 64'h0, "LD0 init", d, e);
            check($sformatf("u%0d zero init", k), d, 64'h0);
            do_req(k, 1, 3'b011, 64'h10, 64'h1122334455667788, "SD10", d, e);
            do_req(k, 0, 3'b011, 64'h10, 64'h0, "LD10", d, e);
            check($sformatf("u%0d LD10 const", k), d, 64'h1122334455667788);
            do_req(k, 1, 3'b011, 64'h20, 64'hA5A5A5A5A5A5A5A5, "SD20", d, e);
            do_req(k, 1, 3'b000, 64'h21, 64'h80, "SB21", d, e);
            do_req(k, 0, 3'b011, 64'h20, 64'h0, "LD20", d, e);
            check($sformatf("u%0d SB lanes", k), d, 64'hA5A5A5A5A5A580A5);
            do_req(k, 0, 3'b000, 64'h21, 64'h0, "LB21", d, e);
            check($sformatf("u%0d LB const", k), d, 64'hFFFFFFFFFFFFFF80);
            do_req(k, 0, 3'b100, 64'h21, 64'h0, "LBU21", d, e);
            check($sformatf("u%0d LBU const", k), d, 64'h80);
            do_req(k, 1, 3'b010, 64'h30, 64'hDEADBEEF, "SW30", d, e);
            do_req(k, 0, 3'b010, 64'h30, 64'h0, "LW30", d, e);
            check($sformatf("u%0d LW const", k), d, 64'hFFFFFFFFDEADBEEF);
            do_req(k, 0, 3'b110, 64'h30, 64'h0, "LWU30", d, e);
            check($sformatf("u%0d LWU const", k), d, 64'h00000000DEADBEEF);
            do_req(k, 0, 3'b001, 64'h32, 64'h0, "LH32", d, e);
            check($sformatf("u%0d LH const", k), d, 64'hFFFFFFFFFFFFDEAD);
            do_req(k, 0, 3'b010, 64'h02, 64'h0, "LW misalign", d, e);
            check($sformatf("u%0d misalign err", k), 64'(e), 64'd1);
            do_req(k, 1, 3'b011, 64'(NB), 64'hFFFFFFFFFFFFFFFF, "SD oob", d, e);
            check($sformatf("u%0d oob err", k), 64'(e), 64'd1);
            do_req(k, 0, 3'b011, 64'h0, 64'h0, "LD0 after oob", d, e);
            check($sformatf("u%0d oob no write", k), d, 64'h0);
            do_req(k, 1, 3'b100, 64'h8, 64'h1234, "S f3=100", d, e);
            check($sformatf("u%0d bad store f3", k), 64'(e), 64'd1);
            do_req(k, 0, 3'b111, 64'h8, 64'h0, "L f3=111", d, e);
            check($sformatf("u%0d bad load f3", k), 64'(e), 64'd1);

            // Reset on the commit edge of a store must abort it.
            do_req(k, 1, 3'b011, 64'h40, 64'h0BADF00D0BADF00D, "SD40 pre", d, e);
            do_req(k, 0, 3'b011, 64'h40, 64'h0, "LD40 pre", d, e);
            req_valid[k] = 1'b1; req_we[k] = 1'b1; req_funct3[k] = 3'b011;
            req_addr[k] = 64'h40; req_wdata[k] = 64'hCAFEBABECAFEBABE;
            if (lat_of(k) == 0) begin
                reset[k] = 1'b1;
                @(negedge clk);
                req_valid[k] = 1'b0;
            end else begin
                @(posedge clk);
                @(negedge clk);
                req_valid[k] = 1'b0;
                repeat (lat_of(k) - 1) @(negedge clk);
                reset[k] = 1'b1;
                @(negedge clk);
            end
            check($sformatf("u%0d rst ready", k), 64'(req_ready[k]), 64'd1);
            check($sformatf("u%0d rst valid", k), 64'(rsp_valid[k]), 64'd0);
            check($sformatf("u%0d rst rdata", k), rsp_rdata[k], 64'h0);
            check($sformatf("u%0d rst err", k), 64'(rsp_err[k]), 64'd0);
            reset[k] = 1'b0;
            for (int c = 0; c < lat_of(k) + 3; c++) begin
                @(negedge clk);
                check($sformatf("u%0d aborted no rsp", k), 64'(rsp_valid[k]), 64'd0);
            end
            do_req(k, 0, 3'b011, 64'h40, 64'h0, "LD40 post", d, e);
            check($sformatf("u%0d aborted store", k), d, 64'h0BADF00D0BADF00D);

            // Continuous req_valid: accepts are LATENCY+2 cycles apart.
            req_valid[k] = 1'b1; req_we[k] = 1'b0; req_funct3[k] = 3'b011; req_addr[k] = 64'h0;
            first = -1; second = -1;
            for (int c = 0; c < 3 * (lat_of(k) + 2); c++) begin
                if (req_ready[k]) begin
                    if (first < 0) first = c;
                    else if (second < 0) second = c;
                end
                @(negedge clk);
            end
            req_valid[k] = 1'b0;
            check($sformatf("u%0d throughput", k), 64'(second - first), 64'(lat_of(k) + 2));
            repeat (lat_of(k) + 3) @(negedge clk);

            // Randomized traffic against the model.
            for (int r = 0; r < 150; r++) begin
                we  = 1'($urandom_range(0, 1));
                f3  = 3'($urandom_range(0, 7));
                if (we && $urandom_range(0, 3) != 0) f3[2] = 1'b0;
                dw  = $urandom_range(0, DEPTH + 1);
                off = $urandom_range(0, 7);
                if ($urandom_range(0, 2) != 0) off = off & ~((1 << f3[1:0]) - 1);
                a   = 64'(dw * 8 + off);
                if ($urandom_range(0, 15) == 0) a = {$urandom, $urandom};
                wd  = {$urandom, $urandom};
                do_req(k, we, f3, a, wd, $sformatf("rnd%0d", r), d, e);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
